// File: rtl/branch_target_buffer_pkg.sv
// Shared BTB definitions: counter encodings, address-width default, PC slice macros.
`ifndef BTB_DEFS_SVH
`define BTB_DEFS_SVH
`define BTB_ADDR_W          32
`define BTB_CTR_SNT         2'b00
`define BTB_CTR_WNT         2'b01
`define BTB_CTR_WT          2'b10
`define BTB_CTR_ST          2'b11
`define BTB_IDX(pc, iw)     pc[(iw)+1:2]
`define BTB_TAG(pc, aw, iw) pc[(aw)-1:(iw)+2]
`endif

package branch_target_buffer_pkg;
  localparam int BTB_ADDR_W_DEF = `BTB_ADDR_W;

  typedef enum logic [1:0] {
    CTR_SNT = `BTB_CTR_SNT,
    CTR_WNT = `BTB_CTR_WNT,
    CTR_WT  = `BTB_CTR_WT,
    CTR_ST  = `BTB_CTR_ST
  } ctr_e;

  typedef struct packed {
    logic hit;
    logic p;
  } shadow_t;
endpackage

// File: rtl/branch_target_buffer_sat_counter2.sv
// 2-bit saturating up/down counter, next-state only.
module sat_counter2
  import branch_target_buffer_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_inc,
  output logic [1:0] o_nxt
);
  always_comb begin
    o_nxt = i_ctr;
    if (i_inc) begin
      if (i_ctr != CTR_ST) o_nxt = i_ctr + 2'd1;
    end else begin
      if (i_ctr != CTR_SNT) o_nxt = i_ctr - 2'd1;
    end
  end
endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: combinational fetch lookup, ALU-stage update, fetch->ALU shadow of hit/prediction.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int INDEX_W = 4,
  parameter int ADDR_W  = BTB_ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_fetch,
  output logic              hit_fetch,
  output logic              p_fetch,
  output logic [ADDR_W-1:0] target_fetch,
  input  logic              stall,
  input  logic              flush,
  output logic              hit_alu,
  output logic              p_alu,
  input  logic [ADDR_W-1:0] pc_alu,
  input  logic [ADDR_W-1:0] target_alu,
  input  logic              result_alu,
  input  logic              write_rp,
  input  logic              write_rt
);
  localparam int TAG_W = ADDR_W - INDEX_W - 2;

  logic [ENTRIES-1:0]             r_valid;
  logic [ENTRIES-1:0][1:0]        r_ctr;
  logic [ENTRIES-1:0][TAG_W-1:0]  r_tag;
  logic [ENTRIES-1:0][ADDR_W-1:0] r_tgt;
  shadow_t                        r_d, r_alu;

  logic [INDEX_W-1:0] w_fidx, w_widx;
  logic [TAG_W-1:0]   w_ftag, w_wtag;
  logic [1:0]         w_ctr_nxt;
  logic               w_unused;

  assign w_fidx   = pc_fetch[INDEX_W+1:2];
  assign w_ftag   = pc_fetch[ADDR_W-1:INDEX_W+2];
  assign w_widx   = pc_alu[INDEX_W+1:2];
  assign w_wtag   = pc_alu[ADDR_W-1:INDEX_W+2];
  assign w_unused = ^{pc_fetch[1:0], pc_alu[1:0]};

  // No bypass: a same-index write this cycle is not visible until the next.
  assign hit_fetch    = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);
  assign p_fetch      = hit_fetch && r_ctr[w_fidx][1];
  assign target_fetch = hit_fetch ? r_tgt[w_fidx] : '0;

  sat_counter2 u_ctr (
    .i_ctr (r_ctr[w_widx]),
    .i_inc (result_alu),
    .o_nxt (w_ctr_nxt)
  );

  // write_rt without write_rp is an illegal command and is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_ctr   <= {ENTRIES{CTR_WNT}};
    end else if (write_rp) begin
      if (write_rt) begin
        r_valid[w_widx] <= 1'b1;
        r_ctr[w_widx]   <= result_alu ? CTR_WT : CTR_WNT;
      end else begin
        r_ctr[w_widx]   <= w_ctr_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (write_rp && write_rt) begin
      r_tag[w_widx] <= w_wtag;
      r_tgt[w_widx] <= target_alu;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d   <= '0;
      r_alu <= '0;
    end else if (flush) begin
      r_d   <= '0;
      r_alu <= '0;
    end else if (!stall) begin
      r_d   <= '{hit: hit_fetch, p: p_fetch};
      r_alu <= r_d;
    end
  end

  assign hit_alu = r_alu.hit;
  assign p_alu   = r_alu.p;
endmodule
